// File: rtl/parser_cfg_pkg.sv
// Shared definitions for the parser control-plane writers: opcodes, header
// layout and rule-record sizing helpers.
package parser_cfg_pkg;

    typedef enum logic [3:0] {
        OP_WRITE      = 4'd1,
        OP_INVALIDATE = 4'd2,
        OP_CLEAR_ALL  = 4'd3
    } cfg_opcode_e;

    localparam int CFG_BEAT_W    = 32;
    localparam int HDR_OP_MSB    = 31;
    localparam int HDR_OP_LSB    = 28;
    localparam int HDR_STAGE_MSB = 23;
    localparam int HDR_STAGE_LSB = 16;
    localparam int HDR_IDX_MSB   = 7;
    localparam int HDR_IDX_LSB   = 0;

    function automatic int rule_rec_width(input int type_num, input int type_width,
                                          input int key_num, input int key_off_w,
                                          input int head_w, input int meta_w);
        return 1 + 2 * type_num * type_width + key_num * (key_off_w + 1) + head_w + meta_w;
    endfunction

    function automatic int rule_rec_beats(input int rec_w);
        return (rec_w + CFG_BEAT_W - 1) / CFG_BEAT_W;
    endfunction

endpackage

// File: rtl/type_rule_unpack.sv
// Slices a packed type-rule record into its fields (LSB first: valid,
// typeData, typeMask, keyOffset, headShift, metaShift).
module type_rule_unpack
    import parser_cfg_pkg::*;
#(
    parameter int TYPE_NUM         = 2,
    parameter int TYPE_WIDTH       = 16,
    parameter int KEY_FILED_NUM    = 4,
    parameter int KEY_OFFSET_WIDTH = 7,
    parameter int HEAD_SHIFT_WIDTH = 8,
    parameter int META_SHIFT_WIDTH = 8,
    parameter int REC_W = rule_rec_width(TYPE_NUM, TYPE_WIDTH, KEY_FILED_NUM,
                                         KEY_OFFSET_WIDTH, HEAD_SHIFT_WIDTH, META_SHIFT_WIDTH)
) (
    input  logic [REC_W-1:0]                              rec,
    output logic                                          valid,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]                type_data,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]                type_mask,
    output logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] key_offset,
    output logic [HEAD_SHIFT_WIDTH-1:0]                   head_shift,
    output logic [META_SHIFT_WIDTH-1:0]                   meta_shift
);

    localparam int TD_W   = TYPE_NUM * TYPE_WIDTH;
    localparam int KO_W   = KEY_FILED_NUM * (KEY_OFFSET_WIDTH + 1);
    localparam int TD_LSB = 1;
    localparam int TM_LSB = TD_LSB + TD_W;
    localparam int KO_LSB = TM_LSB + TD_W;
    localparam int HS_LSB = KO_LSB + KO_W;
    localparam int MS_LSB = HS_LSB + HEAD_SHIFT_WIDTH;

    assign valid      = rec[0];
    assign type_data  = rec[TM_LSB-1:TD_LSB];
    assign type_mask  = rec[KO_LSB-1:TM_LSB];
    assign key_offset = rec[HS_LSB-1:KO_LSB];
    assign head_shift = rec[MS_LSB-1:HS_LSB];
    assign meta_shift = rec[REC_W-1:MS_LSB];

endmodule

// File: rtl/type_rule_cfg_writer.sv
// Per-stage writer for the type-lookup rule table: assembles rule records
// from a 32-bit cfg beat stream and issues one-cycle table write strobes.
module type_rule_cfg_writer
    import parser_cfg_pkg::*;
#(
    parameter int STAGE_ID         = 0,
    parameter int RULE_NUM         = 8,
    parameter int TYPE_NUM         = 2,
    parameter int TYPE_WIDTH       = 16,
    parameter int KEY_FILED_NUM    = 4,
    parameter int KEY_OFFSET_WIDTH = 7,
    parameter int HEAD_SHIFT_WIDTH = 8,
    parameter int META_SHIFT_WIDTH = 8
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_cfg_valid,
    input  logic [31:0]                                   i_cfg_data,
    input  logic                                          i_cfg_last,
    output logic                                          o_cfg_ready,
    output logic [RULE_NUM-1:0]                           o_rule_wren,
    output logic                                          o_typeRule_valid,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]                o_typeRule_typeData,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]                o_typeRule_typeMask,
    output logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] o_typeRule_keyOffset,
    output logic [HEAD_SHIFT_WIDTH-1:0]                   o_typeRule_headShift,
    output logic [META_SHIFT_WIDTH-1:0]                   o_typeRule_metaShift,
    output logic                                          o_cfg_done,
    output logic                                          o_cfg_err,
    output logic [7:0]                                    o_err_cnt
);

    localparam int REC_W = rule_rec_width(TYPE_NUM, TYPE_WIDTH, KEY_FILED_NUM,
                                          KEY_OFFSET_WIDTH, HEAD_SHIFT_WIDTH, META_SHIFT_WIDTH);
    localparam int NB    = rule_rec_beats(REC_W);
    localparam int SR_W  = NB * CFG_BEAT_W;
    localparam int TD_W  = TYPE_NUM * TYPE_WIDTH;
    localparam int KO_W  = KEY_FILED_NUM * (KEY_OFFSET_WIDTH + 1);
    localparam logic [7:0] LAST_BEAT = 8'(NB - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    logic [1:0]          state_r, state_next_s;
    logic [7:0]          beat_cnt_r, beat_cnt_next_s;
    logic [SR_W-1:0]     rec_r, rec_next_s;
    logic [3:0]          op_r, cmd_op_s, hdr_op_s;
    logic [7:0]          stage_r, cmd_stage_s, hdr_stage_s;
    logic [7:0]          idx_r, cmd_idx_s, hdr_idx_s;
    logic                ready_r, accept_s, fmt_err_s, go_commit_s;
    logic                stage_ok_s, idx_ok_s, is_clear_s, is_write_s;
    logic                do_write_s, err_s;
    logic [RULE_NUM-1:0] wren_s, wren_r;
    logic                done_r, err_r;
    logic [7:0]          err_cnt_r;

    logic                valid_s, valid_r;
    logic [TD_W-1:0]     type_data_s, type_data_r, type_mask_s, type_mask_r;
    logic [KO_W-1:0]     key_offset_s, key_offset_r;
    logic [HEAD_SHIFT_WIDTH-1:0] head_shift_s, head_shift_r;
    logic [META_SHIFT_WIDTH-1:0] meta_shift_s, meta_shift_r;
    logic                unused_hdr_s;

    assign accept_s    = i_cfg_valid & ready_r;
    assign hdr_op_s    = i_cfg_data[HDR_OP_MSB:HDR_OP_LSB];
    assign hdr_stage_s = i_cfg_data[HDR_STAGE_MSB:HDR_STAGE_LSB];
    assign hdr_idx_s   = i_cfg_data[HDR_IDX_MSB:HDR_IDX_LSB];
    assign unused_hdr_s = ^{i_cfg_data[27:24], i_cfg_data[15:8], rec_next_s};

    // Beat 0 must end up at the record LSBs, so new beats enter at the top.
    generate
        if (NB == 1) begin : g_rec_one
            assign rec_next_s = i_cfg_data;
        end else begin : g_rec_shift
            assign rec_next_s = {i_cfg_data, rec_r[SR_W-1:CFG_BEAT_W]};
        end
    endgenerate

    type_rule_unpack #(
        .TYPE_NUM         (TYPE_NUM),
        .TYPE_WIDTH       (TYPE_WIDTH),
        .KEY_FILED_NUM    (KEY_FILED_NUM),
        .KEY_OFFSET_WIDTH (KEY_OFFSET_WIDTH),
        .HEAD_SHIFT_WIDTH (HEAD_SHIFT_WIDTH),
        .META_SHIFT_WIDTH (META_SHIFT_WIDTH),
        .REC_W            (REC_W)
    ) u_unpack (
        .rec        (rec_next_s[REC_W-1:0]),
        .valid      (valid_s),
        .type_data  (type_data_s),
        .type_mask  (type_mask_s),
        .key_offset (key_offset_s),
        .head_shift (head_shift_s),
        .meta_shift (meta_shift_s)
    );

    // Command sequencing: header/payload framing checks and next state.
    always_comb begin
        state_next_s    = state_r;
        beat_cnt_next_s = beat_cnt_r;
        fmt_err_s       = 1'b0;
        go_commit_s     = 1'b0;
        cmd_op_s        = op_r;
        cmd_stage_s     = stage_r;
        cmd_idx_s       = idx_r;
        case (state_r)
            ST_IDLE: begin
                cmd_op_s    = hdr_op_s;
                cmd_stage_s = hdr_stage_s;
                cmd_idx_s   = hdr_idx_s;
                if (accept_s) begin
                    if ((hdr_op_s == OP_WRITE) && !i_cfg_last) begin
                        state_next_s    = ST_PAYLOAD;
                        beat_cnt_next_s = 8'd0;
                    end else if (((hdr_op_s == OP_INVALIDATE) || (hdr_op_s == OP_CLEAR_ALL)) && i_cfg_last) begin
                        state_next_s = ST_COMMIT;
                        go_commit_s  = 1'b1;
                    end else begin
                        fmt_err_s    = 1'b1;
                        state_next_s = i_cfg_last ? ST_IDLE : ST_DRAIN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s) begin
                    beat_cnt_next_s = beat_cnt_r + 8'd1;
                    if (beat_cnt_r == LAST_BEAT) begin
                        if (i_cfg_last) begin
                            state_next_s = ST_COMMIT;
                            go_commit_s  = 1'b1;
                        end else begin
                            fmt_err_s    = 1'b1;
                            state_next_s = ST_DRAIN;
                        end
                    end else if (i_cfg_last) begin
                        fmt_err_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_PAYLOAD;
                    end
                end else begin
                    state_next_s = ST_PAYLOAD;
                end
            end
            ST_DRAIN: begin
                if (accept_s && i_cfg_last) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_COMMIT: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Commit decode: target check and strobe pattern for the command.
    always_comb begin
        stage_ok_s = (cmd_stage_s == 8'(STAGE_ID));
        idx_ok_s   = ({1'b0, cmd_idx_s} < 9'(RULE_NUM));
        is_clear_s = (cmd_op_s == OP_CLEAR_ALL);
        is_write_s = (cmd_op_s == OP_WRITE);
        do_write_s = go_commit_s & stage_ok_s & (is_clear_s | idx_ok_s);
        err_s      = fmt_err_s | (go_commit_s & stage_ok_s & ~is_clear_s & ~idx_ok_s);
        wren_s     = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            wren_s[i] = is_clear_s | (cmd_idx_s == 8'(i));
        end
    end

    // Control state, header capture, record assembly and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            beat_cnt_r   <= 8'd0;
            rec_r        <= '0;
            op_r         <= 4'd0;
            stage_r      <= 8'd0;
            idx_r        <= 8'd0;
            ready_r      <= 1'b0;
            wren_r       <= '0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_cnt_r    <= 8'd0;
            valid_r      <= 1'b0;
            type_data_r  <= '0;
            type_mask_r  <= '0;
            key_offset_r <= '0;
            head_shift_r <= '0;
            meta_shift_r <= '0;
        end else begin
            state_r    <= state_next_s;
            beat_cnt_r <= beat_cnt_next_s;
            ready_r    <= (state_next_s != ST_COMMIT);
            if ((state_r == ST_IDLE) && accept_s) begin
                op_r    <= hdr_op_s;
                stage_r <= hdr_stage_s;
                idx_r   <= hdr_idx_s;
            end
            if ((state_r == ST_PAYLOAD) && accept_s) begin
                rec_r <= rec_next_s;
            end
            wren_r <= do_write_s ? wren_s : '0;
            done_r <= do_write_s;
            err_r  <= err_s;
            if (err_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            // Invalidate and clear-all write an all-zero rule.
            if (do_write_s) begin
                valid_r      <= is_write_s ? valid_s      : 1'b0;
                type_data_r  <= is_write_s ? type_data_s  : '0;
                type_mask_r  <= is_write_s ? type_mask_s  : '0;
                key_offset_r <= is_write_s ? key_offset_s : '0;
                head_shift_r <= is_write_s ? head_shift_s : '0;
                meta_shift_r <= is_write_s ? meta_shift_s : '0;
            end
        end
    end

    assign o_cfg_ready          = ready_r;
    assign o_rule_wren          = wren_r;
    assign o_cfg_done           = done_r;
    assign o_cfg_err            = err_r;
    assign o_err_cnt            = err_cnt_r;
    assign o_typeRule_valid     = valid_r;
    assign o_typeRule_typeData  = type_data_r;
    assign o_typeRule_typeMask  = type_mask_r;
    assign o_typeRule_keyOffset = key_offset_r;
    assign o_typeRule_headShift = head_shift_r;
    assign o_typeRule_metaShift = meta_shift_r;

endmodule

// File: tb/tb_type_rule_cfg_writer.sv
// Directed bench for type_rule_cfg_writer: table of well-formed commands plus
// hand sequences for framing errors, reset mid-command and counter saturation.
module tb_type_rule_cfg_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_data = 32'h0;
    logic        cfg_last = 1'b0;
    logic        cfg_ready;
    logic [7:0]  rule_wren;
    logic        r_valid;
    logic [31:0] r_td, r_tm, r_ko;
    logic [7:0]  r_hs, r_ms;
    logic        cfg_done, cfg_err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    type_rule_cfg_writer #(
        .STAGE_ID(0), .RULE_NUM(8), .TYPE_NUM(2), .TYPE_WIDTH(16), .KEY_FILED_NUM(4),
        .KEY_OFFSET_WIDTH(7), .HEAD_SHIFT_WIDTH(8), .META_SHIFT_WIDTH(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .i_cfg_data(cfg_data),
        .i_cfg_last(cfg_last), .o_cfg_ready(cfg_ready), .o_rule_wren(rule_wren),
        .o_typeRule_valid(r_valid), .o_typeRule_typeData(r_td), .o_typeRule_typeMask(r_tm),
        .o_typeRule_keyOffset(r_ko), .o_typeRule_headShift(r_hs), .o_typeRule_metaShift(r_ms),
        .o_cfg_done(cfg_done), .o_cfg_err(cfg_err), .o_err_cnt(err_cnt)
    );

    typedef struct {
        logic [31:0]       hdr;
        logic [3:0][31:0]  pl;
        int                nb;
        logic              commit;
        logic              done;
        logic              err;
        logic [7:0]        wren;
        logic              valid;
        logic [31:0]       td, tm, ko;
        logic [7:0]        hs, ms;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;
    int wren_pulses = 0, done_pulses = 0, err_pulses = 0;
    bit gaps_on = 1'b0;
    logic [7:0]  exp_cnt = 8'd0;
    logic        e_valid = 1'b0;
    logic [31:0] e_td = 32'h0, e_tm = 32'h0, e_ko = 32'h0;
    logic [7:0]  e_hs = 8'h0, e_ms = 8'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rule_wren != 8'h00) wren_pulses++;
            if (cfg_done) done_pulses++;
            if (cfg_err) err_pulses++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic e);
        return (e && (c != 8'hFF)) ? c + 8'd1 : c;
    endfunction

    task automatic chk_fields(input string tag);
        chk({tag, "_valid"}, 32'(r_valid), 32'(e_valid));
        chk({tag, "_typeData"}, r_td, e_td);
        chk({tag, "_typeMask"}, r_tm, e_tm);
        chk({tag, "_keyOffset"}, r_ko, e_ko);
        chk({tag, "_headShift"}, 32'(r_hs), 32'(e_hs));
        chk({tag, "_metaShift"}, 32'(r_ms), 32'(e_ms));
    endtask

    // Present one beat from a negedge and return just after the accepting posedge.
    task automatic send(input logic [31:0] d, input logic l);
        int unsigned gap;
        int waitc;
        gap = gaps_on ? $urandom_range(0, 2) : 0;
        waitc = 0;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (gap) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        while (!cfg_ready && (waitc < 50)) begin
            @(negedge clk);
            waitc++;
        end
        if (!cfg_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, expected 1", waitc);
        end
        @(posedge clk);
    endtask

    task automatic run_table(input string pass);
        vec_t v;
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            send(v.hdr, v.nb == 0);
            for (int b = 0; b < v.nb; b++) send(v.pl[b], b == v.nb - 1);
            @(negedge clk);
            cfg_valid = 1'b0;
            exp_cnt = sat_inc(exp_cnt, v.err);
            if (v.done) begin
                e_valid = v.valid; e_td = v.td; e_tm = v.tm; e_ko = v.ko; e_hs = v.hs; e_ms = v.ms;
            end
            chk($sformatf("%s_v%0d_wren", pass, i), 32'(rule_wren), 32'(v.wren));
            chk($sformatf("%s_v%0d_done", pass, i), 32'(cfg_done), 32'(v.done));
            chk($sformatf("%s_v%0d_err", pass, i), 32'(cfg_err), 32'(v.err));
            chk($sformatf("%s_v%0d_err_cnt", pass, i), 32'(err_cnt), 32'(exp_cnt));
            chk($sformatf("%s_v%0d_ready_n1", pass, i), 32'(cfg_ready), 32'(!v.commit));
            chk_fields($sformatf("%s_v%0d", pass, i));
            @(negedge clk);
            chk($sformatf("%s_v%0d_ready_n2", pass, i), 32'(cfg_ready), 32'd1);
            chk($sformatf("%s_v%0d_wren_n2", pass, i), 32'(rule_wren), 32'd0);
        end
    endtask

    initial begin
        int w0, d0, e0;
        // Record bit k+1 feeds field bit k, so each field is its beats shifted right by one.
        vecs[0] = '{hdr: 32'h1000_0003, pl: {32'h0, 32'h0A0B0C0D, 32'h0000FFFF, 32'h88000001}, nb: 4,
                    commit: 1'b1, done: 1'b1, err: 1'b0, wren: 8'h08, valid: 1'b1,
                    td: 32'hC4000000, tm: 32'h80007FFF, ko: 32'h05058606, hs: 8'h00, ms: 8'h00};
        vecs[1] = '{hdr: 32'h3000_0000, pl: '0, nb: 0, commit: 1'b1, done: 1'b1, err: 1'b0,
                    wren: 8'hFF, valid: 1'b0, td: 32'h0, tm: 32'h0, ko: 32'h0, hs: 8'h00, ms: 8'h00};
        vecs[2] = '{hdr: 32'h1000_0009, pl: '0, nb: 4, commit: 1'b1, done: 1'b0, err: 1'b1,
                    wren: 8'h00, valid: 1'b0, td: 32'h0, tm: 32'h0, ko: 32'h0, hs: 8'h00, ms: 8'h00};
        vecs[3] = '{hdr: 32'h2000_0000, pl: '0, nb: 0, commit: 1'b1, done: 1'b1, err: 1'b0,
                    wren: 8'h01, valid: 1'b0, td: 32'h0, tm: 32'h0, ko: 32'h0, hs: 8'h00, ms: 8'h00};
        vecs[4] = '{hdr: 32'h1000_0007, pl: {32'hFFFF86B4, 32'h12345679, 32'hF0F0F0F1, 32'h55555555}, nb: 4,
                    commit: 1'b1, done: 1'b1, err: 1'b0, wren: 8'h80, valid: 1'b1,
                    td: 32'hAAAAAAAA, tm: 32'hF8787878, ko: 32'h091A2B3C, hs: 8'h5A, ms: 8'hC3};
        vecs[5] = '{hdr: 32'h1001_0002, pl: {32'h1, 32'h2, 32'h3, 32'h4}, nb: 4, commit: 1'b1, done: 1'b0,
                    err: 1'b0, wren: 8'h00, valid: 1'b0, td: 32'h0, tm: 32'h0, ko: 32'h0, hs: 8'h00, ms: 8'h00};
        vecs[6] = '{hdr: 32'h5000_0000, pl: '0, nb: 0, commit: 1'b0, done: 1'b0, err: 1'b1,
                    wren: 8'h00, valid: 1'b0, td: 32'h0, tm: 32'h0, ko: 32'h0, hs: 8'h00, ms: 8'h00};
        vecs[7] = '{hdr: 32'h2000_0008, pl: '0, nb: 0, commit: 1'b1, done: 1'b0, err: 1'b1,
                    wren: 8'h00, valid: 1'b0, td: 32'h0, tm: 32'h0, ko: 32'h0, hs: 8'h00, ms: 8'h00};
        vecs[8] = '{hdr: 32'h3000_00FF, pl: '0, nb: 0, commit: 1'b1, done: 1'b1, err: 1'b0,
                    wren: 8'hFF, valid: 1'b0, td: 32'h0, tm: 32'h0, ko: 32'h0, hs: 8'h00, ms: 8'h00};
        vecs[9] = '{hdr: 32'h2002_0001, pl: '0, nb: 0, commit: 1'b1, done: 1'b0, err: 1'b0,
                    wren: 8'h00, valid: 1'b0, td: 32'h0, tm: 32'h0, ko: 32'h0, hs: 8'h00, ms: 8'h00};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_wren", 32'(rule_wren), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk_fields("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_first_cycle", 32'(cfg_ready), 32'd1);

        run_table("p1");

        // WRITE terminated early on payload beat 2, then a clean INVALIDATE
        send(32'h1000_0001, 1'b0);
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        exp_cnt = sat_inc(exp_cnt, 1'b1);
        chk("short_err", 32'(cfg_err), 32'd1);
        chk("short_wren", 32'(rule_wren), 32'd0);
        chk("short_ready", 32'(cfg_ready), 32'd1);
        chk("short_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        send(32'h2000_0000, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        e_valid = 1'b0; e_td = 32'h0; e_tm = 32'h0; e_ko = 32'h0; e_hs = 8'h0; e_ms = 8'h0;
        chk("inv0_wren", 32'(rule_wren), 32'h01);
        chk("inv0_done", 32'(cfg_done), 32'd1);
        chk_fields("inv0");
        @(negedge clk);

        // WRITE with six payload beats: error at beat 4, rest drained
        w0 = wren_pulses; d0 = done_pulses; e0 = err_pulses;
        send(32'h1000_0002, 1'b0);
        for (int b = 1; b <= 4; b++) send(32'(b), 1'b0);
        @(negedge clk);
        cfg_valid = 1'b0;
        exp_cnt = sat_inc(exp_cnt, 1'b1);
        chk("long_err_at_beat4", 32'(cfg_err), 32'd1);
        chk("long_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        send(32'h5, 1'b0);
        send(32'h6, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("long_ready_after_drain", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        chk("long_wren_pulses", 32'(wren_pulses - w0), 32'd0);
        chk("long_done_pulses", 32'(done_pulses - d0), 32'd0);
        chk("long_err_pulses", 32'(err_pulses - e0), 32'd1);
        chk_fields("long_hold");

        // Reset in the middle of a WRITE payload
        send(32'h1000_0000, 1'b0);
        send(vecs[0].pl[0], 1'b0);
        send(vecs[0].pl[1], 1'b0);
        @(negedge clk);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_cnt = 8'd0;
        e_valid = 1'b0; e_td = 32'h0; e_tm = 32'h0; e_ko = 32'h0; e_hs = 8'h0; e_ms = 8'h0;
        chk("midrst_ready", 32'(cfg_ready), 32'd0);
        chk("midrst_wren", 32'(rule_wren), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        chk_fields("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", 32'(cfg_ready), 32'd1);
        send(32'h1000_0000, 1'b0);
        for (int b = 0; b < 4; b++) send(vecs[0].pl[b], b == 3);
        @(negedge clk);
        cfg_valid = 1'b0;
        e_valid = 1'b1; e_td = 32'hC4000000; e_tm = 32'h80007FFF; e_ko = 32'h05058606;
        chk("fresh_wren", 32'(rule_wren), 32'h01);
        chk("fresh_done", 32'(cfg_done), 32'd1);
        chk_fields("fresh");
        @(negedge clk);

        // Same table with random valid gaps
        gaps_on = 1'b1;
        run_table("p2");
        gaps_on = 1'b0;

        // Error counter saturation
        e0 = err_pulses;
        for (int k = 0; k < 256; k++) begin
            send(32'h5000_0000, 1'b1);
            exp_cnt = sat_inc(exp_cnt, 1'b1);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("sat_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        @(negedge clk);
        chk("sat_err_pulses", 32'(err_pulses - e0), 32'd256);
        send(32'h1000_0001, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("sat_err_cnt_hold", 32'(err_cnt), 32'hFF);
        chk("sat_err_pulse", 32'(cfg_err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
